reg_write_arbiter: RTL and testbench

//  Shares the write ports of a bank of 2**A register_8bits instances among NREQ requesters.

---
 rtl/reg_write_arbiter_pkg.sv | 16 +
 rtl/reg_write_arbiter_rr_pick.sv | 34 +++
 rtl/reg_write_arbiter.sv | 91 +++++++++
 tb/tb_reg_write_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// Holds the FSM state encoding and the index-width helper.
package reg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_t;

    // Bit width needed to index n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req_mask,
// searching upward from ptr and wrapping N-1 -> 0.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_mask,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW:0] pos;

    // Walking from the far end down lets the candidate nearest ptr win last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(N)) begin
                pos = pos - (IW + 1)'(N);
            end
            if (req_mask[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for a bank of 2**A registers, one write per
// cycle, with optional locked bursts of up to BURST_MAX beats.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int  NREQ      = 4,
    parameter int  A         = 3,
    parameter int  D         = 8,
    parameter int  BURST_MAX = 8,
    localparam int IW        = idx_width(NREQ),
    localparam int NREG      = 1 << A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*A-1:0] addr,
    input  logic [NREQ*D-1:0] wdata,
    output logic [NREQ-1:0]   ack,
    output logic [NREG-1:0]   sel,
    output logic [D-1:0]      data_out,
    output logic [IW-1:0]     gnt_id,
    output logic              busy
);

    localparam int BW = idx_width(BURST_MAX);

    arb_state_t      fsm;
    logic [IW-1:0]   owner;
    logic            valid;
    logic [IW-1:0]   rr_ptr;
    logic [BW-1:0]   beat_cnt;

    logic            write;
    logic [NREQ-1:0] served;
    logic [NREQ-1:0] cand;
    logic [A-1:0]    owner_addr;
    logic            keep_lock;
    logic            found;
    logic [IW-1:0]   win;

    assign write      = valid & req[owner];
    assign served     = write ? (NREQ'(1) << owner) : '0;
    assign owner_addr = addr[owner*A +: A];

    // The requester written this cycle sits out the next arbitration round.
    assign cand       = req & ~served;

    assign keep_lock  = (fsm == LOCK) && write && lock[owner] &&
                        (int'(beat_cnt) < BURST_MAX - 1);

    // Bank strobes are killed for as long as reset is held low.
    assign ack        = reset ? served : '0;
    assign sel        = (reset && write) ? (NREG'(1) << owner_addr) : '0;
    assign data_out   = valid ? wdata[owner*D +: D] : '0;
    assign gnt_id     = owner;
    assign busy       = valid;

    rr_pick #(
        .N(NREQ)
    ) u_pick (
        .req_mask(cand),
        .ptr     (rr_ptr),
        .found   (found),
        .idx     (win)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm      <= IDLE;
            owner    <= '0;
            valid    <= 1'b0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (keep_lock) begin
            beat_cnt <= beat_cnt + 1'b1;
        end else if (found) begin
            // IDLE, finished GRANT and ended LOCK all re-arbitrate the same way.
            fsm      <= lock[win] ? LOCK : GRANT;
            owner    <= win;
            valid    <= 1'b1;
            beat_cnt <= '0;
            rr_ptr   <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end else begin
            fsm      <= IDLE;
            valid    <= 1'b0;
            beat_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (NREQ=4, A=3, D=8, BURST_MAX=8).
// Inputs change just after posedge; outputs are sampled on the following negedge.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [7:0]  sel;
    logic [7:0]  data_out;
    logic [1:0]  gnt_id;
    logic        busy;

    int num_checks = 0;
    int num_fail   = 0;

    // Requester i writes register {0,1,5,7}[i] with data {10,21,A5,3C}[i].
    logic [7:0] exp_sel_tab  [4] = '{8'h01, 8'h02, 8'h20, 8'h80};
    logic [7:0] exp_data_tab [4] = '{8'h10, 8'h21, 8'hA5, 8'h3C};

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .NREQ(4), .A(3), .D(8), .BURST_MAX(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .sel     (sel),
        .data_out(data_out),
        .gnt_id  (gnt_id),
        .busy    (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [3:0] l);
        @(posedge clk);
        #1;
        reset = rst;
        req   = r;
        lock  = l;
        @(negedge clk);
    endtask

    task automatic expectWrite(input string tag, input int id);
        checkOutput({tag, "_ack"},  32'(ack),      32'(4'b0001 << id));
        checkOutput({tag, "_gnt"},  32'(gnt_id),   32'(id));
        checkOutput({tag, "_sel"},  32'(sel),      32'(exp_sel_tab[id]));
        checkOutput({tag, "_data"}, 32'(data_out), 32'(exp_data_tab[id]));
        checkOutput({tag, "_busy"}, 32'(busy),     32'd1);
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, "_ack"},  32'(ack),  32'd0);
        checkOutput({tag, "_sel"},  32'(sel),  32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        addr  = {3'd7, 3'd5, 3'd1, 3'd0};
        wdata = {8'h3C, 8'hA5, 8'h21, 8'h10};

        $display("[TB] reset held with all requesters active");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0000);
            expectIdle($sformatf("rst_hold%0d", i));
            checkOutput($sformatf("rst_data%0d", i), 32'(data_out), 32'd0);
        end
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        expectIdle("rst_release");

        $display("[TB] round-robin with all requesters held");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 4'b1111, 4'b0000);
            expectWrite($sformatf("rr%0d", k), k % 4);
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        checkOutput("drop_ack", 32'(ack), 32'd0);
        checkOutput("drop_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        expectIdle("drop_idle");

        $display("[TB] single write from requester 2");
        applyStimulus(1'b1, 4'b0100, 4'b0000);
        expectIdle("t2_req");
        applyStimulus(1'b1, 4'b0100, 4'b0000);
        expectWrite("t2_write", 2);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        expectIdle("t2_done");

        $display("[TB] lone requester 0 without lock");
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        expectIdle("t5_start");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 4'b0001, 4'b0000);
            if (k % 2 == 0) expectWrite($sformatf("t5_c%0d", k), 0);
            else            expectIdle($sformatf("t5_c%0d", k));
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        checkOutput("t5_release_ack", 32'(ack), 32'd0);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        expectIdle("t5_idle");

        $display("[TB] locked burst from requester 1 against requester 3");
        applyStimulus(1'b1, 4'b1010, 4'b0010);
        expectIdle("t4_start");
        for (int k = 0; k < 13; k++) begin
            applyStimulus(1'b1, 4'b1010, 4'b0010);
            expectWrite($sformatf("t4_b%0d", k), (k == 8) ? 3 : 1);
        end

        $display("[TB] reset in the middle of a locked burst");
        applyStimulus(1'b0, 4'b1010, 4'b0010);
        checkOutput("t6_ack_forced", 32'(ack), 32'd0);
        checkOutput("t6_sel_forced", 32'(sel), 32'd0);
        checkOutput("t6_busy_before", 32'(busy), 32'd1);
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        expectIdle("t6_after_rst");
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        expectWrite("t6_restart", 0);
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        expectWrite("t6_next", 1);
        applyStimulus(1'b1, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
